// File: rtl/minterm_sweep_gen_pkg.sv
// Shared types and defaults for the minterm sweep generator.
// Holds the FSM state enum and the default input count / expected mask.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sweep_state_t;

    localparam int         SWEEP_N_IN_DEF = 3;
    localparam logic [7:0] SWEEP_EXP_DEF  = 8'hD5;

endpackage

// File: rtl/minterm_sweep_gen_if.sv
// Stimulus/capture bundle between the sweep generator and its user.
// master: generator side (drives abc/busy/done/mask/match, takes start/f_in).
// slave : user side (drives start and the function output f_in).
interface minterm_sweep_gen_if #(
    parameter int N_IN = 3
);

    logic                 start;
    logic [N_IN-1:0]      abc;
    logic                 f_in;
    logic                 busy;
    logic                 done;
    logic [2**N_IN-1:0]   mask;
    logic                 match;

    modport master (
        input  start,
        input  f_in,
        output abc,
        output busy,
        output done,
        output mask,
        output match
    );

    modport slave (
        output start,
        output f_in,
        input  abc,
        input  busy,
        input  done,
        input  mask,
        input  match
    );

endinterface

// File: rtl/minterm_sweep_gen_settle_timer.sv
// Settle down-counter: load, decrement-to-zero, zero flag.
// Ports: clk, rst, load_i/load_val_i (reload), dec_i (count), zero_o.
module sweep_settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/minterm_sweep_gen.sv
// Sweeps all 2**N_IN input vectors, samples f_in after SETTLE cycles each,
// and builds the observed truth table in mask. Ports: clk, rst, bus_m
// (start, abc, f_in, busy, done, mask, match). Optional comparator against
// EXP_MASK is enabled by the macro SWEEP_COMPARE_EN; otherwise match is 0.
module minterm_sweep_gen
    import sweep_pkg::*;
#(
    parameter int N_IN   = SWEEP_N_IN_DEF,
    parameter int SETTLE = 1
`ifdef SWEEP_COMPARE_EN
    ,
    parameter logic [2**N_IN-1:0] EXP_MASK = SWEEP_EXP_DEF
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    minterm_sweep_gen_if.master   bus_m
);

    localparam int NV = 2**N_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [N_IN-1:0] LAST   = N_IN'(NV - 1);
    localparam logic [CW-1:0]   RELOAD = CW'(SETTLE - 1);

    sweep_state_t    state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [N_IN-1:0] abc_q, abc_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [NV-1:0]   mask_q, mask_d;

    logic tmr_load;
    logic tmr_dec;
    logic tmr_zero;

`ifdef SWEEP_COMPARE_EN
    logic match_q, match_d;
`endif

    sweep_settle_timer #(
        .W (CW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (RELOAD),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        abc_d    = abc_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        mask_d   = mask_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
`ifdef SWEEP_COMPARE_EN
        match_d  = match_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus_m.start) begin
                    mask_d   = '0;
                    idx_d    = '0;
                    abc_d    = '0;
                    busy_d   = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = RUN;
`ifdef SWEEP_COMPARE_EN
                    match_d  = 1'b0;
`endif
                end
            end
            RUN: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else begin
                    mask_d[idx_q] = bus_m.f_in;
                    if (idx_q == LAST) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        abc_d   = '0;
                        state_d = DONE;
`ifdef SWEEP_COMPARE_EN
                        // mask_q lacks the final bit yet; splice in f_in.
                        match_d = ({bus_m.f_in, mask_q[NV-2:0]} == EXP_MASK);
`endif
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        abc_d    = idx_q + 1'b1;
                        tmr_load = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            abc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            abc_q   <= abc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mask_q  <= mask_d;
        end
    end

`ifdef SWEEP_COMPARE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign bus_m.match = match_q;
`else
    assign bus_m.match = 1'b0;
`endif

    assign bus_m.abc  = abc_q;
    assign bus_m.busy = busy_q;
    assign bus_m.done = done_q;
    assign bus_m.mask = mask_q;

endmodule

// File: tb/tb_minterm_sweep_gen.sv
// Randomized bench for minterm_sweep_gen (SETTLE=1 and SETTLE=3 instances).
// The function under test is a truth-table lookup; the model predicts timing.
module tb_minterm_sweep_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tt;
    int         n_vec = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    minterm_sweep_gen_if #(.N_IN(3)) if_a ();
    minterm_sweep_gen_if #(.N_IN(3)) if_b ();

    assign if_a.f_in = tt[if_a.abc];
    assign if_b.f_in = tt[if_b.abc];

    minterm_sweep_gen #(.N_IN(3), .SETTLE(1)) u_a (
        .clk   (clk),
        .rst   (rst),
        .bus_m (if_a.master)
    );

    minterm_sweep_gen #(.N_IN(3), .SETTLE(3)) u_b (
        .clk   (clk),
        .rst   (rst),
        .bus_m (if_b.master)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] g_abc(int d);
        return (d == 0) ? if_a.abc : if_b.abc;
    endfunction
    function automatic logic g_busy(int d);
        return (d == 0) ? if_a.busy : if_b.busy;
    endfunction
    function automatic logic g_done(int d);
        return (d == 0) ? if_a.done : if_b.done;
    endfunction
    function automatic logic [7:0] g_mask(int d);
        return (d == 0) ? if_a.mask : if_b.mask;
    endfunction
    function automatic logic g_match(int d);
        return (d == 0) ? if_a.match : if_b.match;
    endfunction

    task automatic set_start(int d, logic v);
        if (d == 0) if_a.start = v;
        else        if_b.start = v;
    endtask

    function automatic logic exp_match(logic [7:0] t);
`ifdef SWEEP_COMPARE_EN
        return (t == 8'hD5);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk_idle(int d, string tag);
        chk({tag, ".abc"},   32'(g_abc(d)),   0);
        chk({tag, ".busy"},  32'(g_busy(d)),  0);
        chk({tag, ".done"},  32'(g_done(d)),  0);
        chk({tag, ".mask"},  32'(g_mask(d)),  0);
        chk({tag, ".match"}, 32'(g_match(d)), 0);
    endtask

    // Full sweep from the idle state; restart_e re-pulses start before
    // that edge, abort_k asserts reset while vector abort_k is on abc.
    task automatic sweep(int d, logic [7:0] t, int restart_e, int abort_k);
        int s;
        int last;
        int k;
        s    = (d == 0) ? 1 : 3;
        last = 8 * s;
        tt   = t;
        @(negedge clk);
        set_start(d, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(d, 1'b0);
        for (int e = 1; e <= last; e++) begin
            k = (e - 1) / s;
            if (k == abort_k) begin
                rst = 1'b1;
                #1;
                chk_idle(d, "abort");
                @(negedge clk);
                rst = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("abort.nodone", 32'(g_done(d)), 0);
                    chk("abort.busy",   32'(g_busy(d)), 0);
                end
                return;
            end
            chk("run.abc",   32'(g_abc(d)),   32'(k));
            chk("run.busy",  32'(g_busy(d)),  1);
            chk("run.done",  32'(g_done(d)),  0);
            chk("run.match", 32'(g_match(d)), 0);
            set_start(d, e == restart_e);
            @(negedge clk);
        end
        set_start(d, 1'b0);
        chk("end.done",  32'(g_done(d)),  1);
        chk("end.busy",  32'(g_busy(d)),  0);
        chk("end.abc",   32'(g_abc(d)),   0);
        chk("end.mask",  32'(g_mask(d)),  32'(t));
        chk("end.match", 32'(g_match(d)), 32'(exp_match(t)));
        @(negedge clk);
        chk("hold.done",  32'(g_done(d)),  0);
        chk("hold.busy",  32'(g_busy(d)),  0);
        chk("hold.mask",  32'(g_mask(d)),  32'(t));
        chk("hold.match", 32'(g_match(d)), 32'(exp_match(t)));
    endtask

    initial begin
        int d;
        logic [7:0] t;
        rst        = 1'b1;
        tt         = 8'h00;
        if_a.start = 1'b0;
        if_b.start = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle(0, "rst_a");
        chk_idle(1, "rst_b");
        rst = 1'b0;

        sweep(0, 8'hD5, -1, -1);
        sweep(0, 8'h00, -1, -1);
        sweep(1, 8'hF0, -1, -1);
        sweep(0, 8'h5A, 4, -1);
        sweep(0, 8'hD5, -1, 5);
        chk_idle(0, "post_abort");
        sweep(0, 8'hD5, -1, -1);

        for (int i = 0; i < 10; i++) begin
            d = int'($urandom_range(0, 1));
            t = 8'($urandom);
            if (i == 3) t = 8'hD5;
            sweep(d, t, int'($urandom_range(1, (d == 0) ? 8 : 24)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
